// File: rtl/mips_pkg.sv
// Shared MIPS definitions: funct codes for the HI/LO instruction group and the
// multiply/divide unit state and mode encodings.
package mips_pkg;

  localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
  localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
  localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
  localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
  localparam logic [5:0] FUNCT_MULT  = 6'b011000;
  localparam logic [5:0] FUNCT_MULTU = 6'b011001;
  localparam logic [5:0] FUNCT_DIV   = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

  localparam logic [1:0] ST_IDLE_ENC   = 2'd0;
  localparam logic [1:0] ST_CALC_ENC   = 2'd1;
  localparam logic [1:0] ST_FINISH_ENC = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE   = ST_IDLE_ENC,
    ST_CALC   = ST_CALC_ENC,
    ST_FINISH = ST_FINISH_ENC
  } md_state_t;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } md_mode_t;

endpackage

// File: rtl/md_iter_step.sv
// One radix-2 iteration: shift-add multiply step or restoring divide step.
// acc holds {partial product, multiplier} or {remainder, dividend/quotient}.
module md_iter_step
  import mips_pkg::*;
#(
  parameter int NB_DATA = 32
) (
  input  md_mode_t                 mode,
  input  logic [2*NB_DATA-1:0]     acc,
  input  logic [NB_DATA-1:0]       operand,
  output logic [2*NB_DATA-1:0]     acc_next
);

  logic [NB_DATA:0]   mul_sum;
  logic [NB_DATA:0]   rem_sh;
  logic [NB_DATA+1:0] diff;
  logic               fits;

  always_comb begin
    mul_sum = {1'b0, acc[2*NB_DATA-1:NB_DATA]} + (acc[0] ? {1'b0, operand} : '0);
    rem_sh  = {acc[2*NB_DATA-1:NB_DATA], acc[NB_DATA-1]};
    diff    = {1'b0, rem_sh} - {2'b00, operand};
    // A successful trial subtraction always lands below 2^NB_DATA, so both top bits clear.
    fits    = ~|diff[NB_DATA+1:NB_DATA];
    if (mode == MODE_DIV) begin
      acc_next = fits ? {diff[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b1}
                      : {rem_sh[NB_DATA-1:0], acc[NB_DATA-2:0], 1'b0};
    end else begin
      acc_next = {mul_sum, acc[NB_DATA-1:1]};
    end
  end

endmodule

// File: rtl/mult_div_unit.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit owning the architectural HI/LO registers.
// state  | meaning
// IDLE   | waiting; MTHI/MTLO write HI/LO directly, MULT/DIV latch operands
// CALC   | one iteration per cycle, counter runs NB_DATA-1 down to 0
// FINISH | sign correction, HI/LO write, done pulse on the next cycle
module mult_div_unit
  import mips_pkg::*;
#(
  parameter int NB_DATA  = 32,
  parameter int NB_FUNCT = 6
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_start,
  input  logic [NB_FUNCT-1:0] i_funct,
  input  logic [NB_DATA-1:0]  i_operand_a,
  input  logic [NB_DATA-1:0]  i_operand_b,
  output logic                o_busy,
  output logic                o_done,
  output logic [NB_DATA-1:0]  o_hi,
  output logic [NB_DATA-1:0]  o_lo
);

  localparam int              NB_CNT   = $clog2(NB_DATA);
  localparam logic [NB_CNT-1:0] CNT_INIT = NB_CNT'(NB_DATA - 1);

  md_state_t            state, state_next;
  md_mode_t             mode;
  logic [NB_CNT-1:0]    cnt;
  logic [2*NB_DATA-1:0] acc, acc_next, prod_fix;
  logic [NB_DATA-1:0]   operand, abs_a, abs_b, quo_fix, rem_fix;
  logic                 res_neg, rem_neg, div_zero;
  logic                 is_mul, is_div, is_signed, is_mthi, is_mtlo, load_op;

  always_comb begin
    is_mul    = (i_funct == NB_FUNCT'(FUNCT_MULT)) || (i_funct == NB_FUNCT'(FUNCT_MULTU));
    is_div    = (i_funct == NB_FUNCT'(FUNCT_DIV))  || (i_funct == NB_FUNCT'(FUNCT_DIVU));
    is_signed = (i_funct == NB_FUNCT'(FUNCT_MULT)) || (i_funct == NB_FUNCT'(FUNCT_DIV));
    is_mthi   = (i_funct == NB_FUNCT'(FUNCT_MTHI));
    is_mtlo   = (i_funct == NB_FUNCT'(FUNCT_MTLO));
    abs_a     = (is_signed && i_operand_a[NB_DATA-1]) ? -i_operand_a : i_operand_a;
    abs_b     = (is_signed && i_operand_b[NB_DATA-1]) ? -i_operand_b : i_operand_b;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    load_op    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_start && (is_mul || is_div)) begin
          load_op    = 1'b1;
          state_next = ST_CALC;
        end
      end
      ST_CALC:   if (cnt == '0) state_next = ST_FINISH;
      ST_FINISH: state_next = ST_IDLE;
      default:   state_next = ST_IDLE;
    endcase
    o_busy = (state != ST_IDLE);
  end

  md_iter_step #(.NB_DATA(NB_DATA)) u_step (
    .mode     (mode),
    .acc      (acc),
    .operand  (operand),
    .acc_next (acc_next)
  );

  // Divide by zero keeps |a| as remainder, so sign correction restores a for HI.
  always_comb begin
    prod_fix = res_neg ? -acc : acc;
    quo_fix  = div_zero ? '1 : (res_neg ? -acc[NB_DATA-1:0] : acc[NB_DATA-1:0]);
    rem_fix  = rem_neg ? -acc[2*NB_DATA-1:NB_DATA] : acc[2*NB_DATA-1:NB_DATA];
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      mode     <= MODE_MUL;
      cnt      <= '0;
      acc      <= '0;
      operand  <= '0;
      res_neg  <= 1'b0;
      rem_neg  <= 1'b0;
      div_zero <= 1'b0;
      o_hi     <= '0;
      o_lo     <= '0;
      o_done   <= 1'b0;
    end else begin
      o_done <= 1'b0;
      if (load_op) begin
        cnt      <= CNT_INIT;
        mode     <= is_div ? MODE_DIV : MODE_MUL;
        res_neg  <= is_signed & (i_operand_a[NB_DATA-1] ^ i_operand_b[NB_DATA-1]);
        rem_neg  <= is_signed & is_div & i_operand_a[NB_DATA-1];
        div_zero <= is_div & (i_operand_b == '0);
        if (is_div) begin
          acc     <= {{NB_DATA{1'b0}}, abs_a};
          operand <= abs_b;
        end else begin
          acc     <= {{NB_DATA{1'b0}}, abs_b};
          operand <= abs_a;
        end
      end else if (state == ST_IDLE && i_start) begin
        if (is_mthi) o_hi <= i_operand_a;
        if (is_mtlo) o_lo <= i_operand_a;
      end
      if (state == ST_CALC) begin
        acc <= acc_next;
        cnt <= cnt - 1'b1;
      end
      if (state == ST_FINISH) begin
        if (mode == MODE_DIV) begin
          o_hi <= rem_fix;
          o_lo <= quo_fix;
        end else begin
          o_hi <= prod_fix[2*NB_DATA-1:NB_DATA];
          o_lo <= prod_fix[NB_DATA-1:0];
        end
        o_done <= 1'b1;
      end
    end
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
Multi-cycle execution unit beside the single-cycle EX-stage arithmetic path. It handles the MIPS R-type functs that path does not: MULT, MULTU, DIV, DIVU, MTHI and MTLO. It owns the architectural HI/LO registers, which MFHI/MFLO read. While an operation is in flight it raises o_busy, which the hazard unit uses to stall the pipeline.

Parameters:
- NB_DATA, 32, operand and HI/LO width.
- NB_FUNCT, 6, width of the funct code input.

Ports:
- i_clk  input  1  system clock; all state updates on the rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_start  input  1  request strobe; sampled only in IDLE.
- i_funct  input  NB_FUNCT  operation select: 011000 MULT, 011001 MULTU, 011010 DIV, 011011 DIVU, 010001 MTHI, 010011 MTLO.
- i_operand_a  input  NB_DATA  rs value (multiplicand / dividend / MTHI-MTLO source).
- i_operand_b  input  NB_DATA  rt value (multiplier / divisor).
- o_busy  output  1  high whenever state != IDLE.
- o_done  output  1  one-cycle pulse when a MULT/DIV result has been written to HI/LO.
- o_hi  output  NB_DATA  HI register contents (registered).
- o_lo  output  NB_DATA  LO register contents (registered).

Behaviour:
- Reset (async, any state): state=IDLE, HI=0, LO=0, o_busy=0, o_done=0, iteration counter=0.
- FSM states: IDLE, CALC, FINISH.
- IDLE + i_start + MULT/MULTU/DIV/DIVU (edge 0):
  - latch operands; for signed ops latch absolute values, result-sign flag and remainder-sign flag;
  - counter=NB_DATA-1; go to CALC.
- IDLE + i_start + MTHI/MTLO: HI (resp. LO) <= i_operand_a on that edge; stay IDLE; no o_done, no busy.
- IDLE + i_start + any other funct: ignored. IDLE + !i_start: hold.
- CALC: one radix-2 step per cycle.
  - Multiply: shift-add on a 2*NB_DATA product register.
  - Divide: restoring, one quotient bit per cycle.
  - Counter decrements each step; the step taken with counter==0 moves to FINISH (edge NB_DATA).
- FINISH (edge NB_DATA+1):
  - apply sign correction and write HI/LO;
  - o_done=1 for exactly the following cycle;
  - return to IDLE.
- Latency: start sampled at edge 0; HI/LO valid and o_done high after edge 33 (NB_DATA=32). o_busy is high for cycles 1..33.
- i_start while busy: ignored; operands and funct are never re-sampled mid-operation.
- Multiply results:
  - HI = upper NB_DATA bits, LO = lower NB_DATA bits of the product;
  - MULT result is two's-complement signed, MULTU unsigned.
- Divide results: LO = quotient, HI = remainder.
  - Signed quotient sign = sign(a) XOR sign(b); remainder sign = sign(a), truncation toward zero.
- Divide by zero (DIV or DIVU): full latency is still taken; HI = i_operand_a as latched, LO = all ones.
- Signed overflow, DIV 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- Reset asserted mid-operation: operation aborted, HI/LO cleared, no o_done.
- o_hi/o_lo change only on the FINISH edge, MTHI/MTLO writes, or reset.
- During CALC, o_hi/o_lo keep their pre-operation values.

Decomposition:
- Shared package mips_pkg (existing) gains: funct constants FUNCT_MULT, FUNCT_MULTU, FUNCT_DIV, FUNCT_DIVU, FUNCT_MTHI, FUNCT_MTLO, FUNCT_MFHI, FUNCT_MFLO; FSM state encoding localparams for IDLE/CALC/FINISH.
- One sub-module, md_iter_step: combinational single iteration, taking mode, accumulator and operand and returning next accumulator/quotient bits. The top level holds the FSM, counter, sign flags and HI/LO.

Test Plan:
- MULT a=0xFFFFFFFD (-3), b=5 -> after 34 cycles HI=0xFFFFFFFF, LO=0xFFFFFFF1, o_done single pulse, o_busy high exactly 33 cycles.
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001.
- DIV a=0xFFFFFFF9 (-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0x00000000.
- DIVU a=0x00001234, b=0 -> HI=0x00001234, LO=0xFFFFFFFF, latency unchanged.
- MTHI a=0xCAFEF00D, then MULTU 3*4 started with i_start re-pulsed at cycle 10 using different operands, then i_rst_n low at cycle 20 of a second MULTU:
  - HI=0xCAFEF00D the next cycle;
  - the cycle-10 re-pulse is ignored and the result is HI=0, LO=0x0000000C;
  - reset mid-op gives immediate HI=LO=0, busy=0, no done pulse.
